dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- CPU-side initiator for the 256x64 data RAM, the requesting end of the RAM address/in/write/out interface.
- Accepts LEGv8 load/store requests on 64-bit byte addresses. Issues the RAM word accesses.
- Performs read-modify-write for sub-doubleword stores.
- Extracts and extends sub-doubleword load data.
- Sits between the execute/memory stage and the data RAM.

Parameters:
- ADDR_BITS, 8, RAM word-index width; RAM depth = 2**ADDR_BITS doublewords.

Ports:
- clock  input  1  system clock; all state updates on posedge. RAM samples on negedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; accepted only when ready=1.
- store  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
- sext  input  1  loads only: 1 sign-extends (LDURSW), 0 zero-extends.
- address  input  64  byte address.
- wdata  input  64  store data; low 8/16/32/64 bits used.
- ready  output  1  controller idle, can accept req.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: request rejected, no RAM access.
- rdata  output  64  load result; valid with done, held until next done.
- ram_address  output  ADDR_BITS  to RAM address (registered).
- ram_in  output  64  to RAM in (registered).
- ram_write  output  1  to RAM write (registered).
- ram_out  input  64  from RAM out.

Behaviour:
- Word index = address[ADDR_BITS+2:3]; offset = address[2:0].
- Byte ordering is little-endian: byte k occupies bits [8k+7:8k].
- Error conditions (checked at accept):
  - Misaligned: offset not a multiple of the access size.
  - Out of range: address[63:ADDR_BITS+3] nonzero.
  - On error: no RAM access, state goes to DONE with err=1, rdata unchanged.
- States: IDLE, RD, WR, DONE.
- IDLE: ready=1.
  - On req: latch store, size, sext, offset and wdata; load ram_address with the word index.
  - Next state is DONE on error, WR on a doubleword store, RD otherwise.
- RD:
  - RAM captures the address at the mid-cycle negedge; ram_out is valid at the closing posedge and is captured there.
  - Load: rdata = selected field shifted down by offset*8, then zero- or sign-extended per sext. Doubleword loads ignore sext. Next state DONE.
  - Sub-doubleword store: ram_in = captured word with the addressed byte lanes replaced by the wdata low bits. Next state WR.
- WR: ram_write=1 for exactly this cycle; the RAM writes at its negedge. Next state DONE.
- DONE: done=1 and ready=0 for one cycle. Next state IDLE.
- ram_write is 0 in every state except WR. ram_address and ram_in hold their values until the next accept.
- Latency from the accept edge to the done cycle:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Doubleword store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
  - Throughput: at most one request per (latency+1) cycles.
- req is ignored whenever ready=0; there is no queueing.
- Reset, while asserted and on the following cycle:
  - State goes to IDLE.
  - ready=1 after reset releases.
  - done, err, ram_write = 0; rdata, ram_in, ram_address = 0.
- Reset during an in-flight request aborts it; no done is produced.
  - If reset is asserted during the WR cycle, the RAM write at that cycle's negedge still occurs, because ram_write is registered. The write is therefore complete or not started, never partial.
- Reset asserted in the same cycle as req: the request is dropped.

Test Plan:
- Doubleword round trip: store address=0x18, size=11, wdata=0x0123456789ABCDEF. Required: done 2 cycles after accept, RAM word 3 written. Then load the same address: rdata=0x0123456789ABCDEF, err=0.
- Byte RMW: RAM word 3 = 0x0123456789ABCDEF; store byte address=0x1D, wdata=0xFF. Required: ram_write high exactly one cycle, word 3 becomes 0x0123FF6789ABCDEF, done 3 cycles after accept.
- Load extension: word 5 = 0x80000000_7FFF8001.
  - LDURSW address=0x2C: rdata=0xFFFFFFFF80000000.
  - Halfword zero-extend at 0x28: rdata=0x0000000000008001.
  - Byte at 0x2A: rdata=0x00000000000000FF.
- Errors: half load at address 0x03 and doubleword at 0x800. Required for each: done plus err one cycle after accept, ram_write never asserted, rdata unchanged.
- Back-pressure: hold req high continuously with 4 queued loads. Required: exactly one accept per 3 cycles, ready low between accepts, 4 done pulses.
- Reset mid-operation:
  - Assert reset in the RD cycle of a byte store: no write, no done, ready=1 after release.
  - Assert reset in the WR cycle: word fully updated, no done.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : CPU-side load/store initiator for the 2**ADDR_BITS x 64 data RAM,
//            with read-modify-write for sub-doubleword stores.
// Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 store,
    input  logic [1:0]           size,
    input  logic                 sext,
    input  logic [63:0]          address,
    input  logic [63:0]          wdata,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [63:0]          rdata,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic [63:0]          ram_in,
    output logic                 ram_write,
    input  logic [63:0]          ram_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic                 r_store;
    logic [1:0]           r_size;
    logic                 r_sext;
    logic [2:0]           r_offset;
    logic [63:0]          r_wdata;
    logic                 r_err;
    logic [63:0]          r_rdata;
    logic [ADDR_BITS-1:0] r_ram_address;
    logic [63:0]          r_ram_in;
    logic                 r_ram_write;

    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic                 w_reject;
    logic [5:0]           w_shift;
    logic [63:0]          w_field_mask;
    logic [63:0]          w_shifted;
    logic [63:0]          w_load_result;
    logic [63:0]          w_merged;

    // Alignment is checked against the incoming request, before it is latched.
    always_comb begin
        w_misaligned = 1'b0;
        case (size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = address[0];
            2'b10:   w_misaligned = |address[1:0];
            default: w_misaligned = |address[2:0];
        endcase
    end

    assign w_out_of_range = |address[63:ADDR_BITS+3];
    assign w_reject       = w_misaligned | w_out_of_range;

    assign w_shift = {r_offset, 3'b000};

    always_comb begin
        w_field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (r_size)
            2'b00:   w_field_mask = 64'h0000_0000_0000_00FF << w_shift;
            2'b01:   w_field_mask = 64'h0000_0000_0000_FFFF << w_shift;
            2'b10:   w_field_mask = 64'h0000_0000_FFFF_FFFF << w_shift;
            default: w_field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign w_shifted = ram_out >> w_shift;

    always_comb begin
        w_load_result = ram_out;
        case (r_size)
            2'b00:   w_load_result = {{56{r_sext & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_result = {{48{r_sext & w_shifted[15]}}, w_shifted[15:0]};
            2'b10:   w_load_result = {{32{r_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_result = ram_out;
        endcase
    end

    // Untouched byte lanes come from the word just read back.
    assign w_merged = (ram_out & ~w_field_mask) | ((r_wdata << w_shift) & w_field_mask);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_store       <= 1'b0;
            r_size        <= 2'b00;
            r_sext        <= 1'b0;
            r_offset      <= 3'd0;
            r_wdata       <= 64'd0;
            r_err         <= 1'b0;
            r_rdata       <= 64'd0;
            r_ram_address <= '0;
            r_ram_in      <= 64'd0;
            r_ram_write   <= 1'b0;
        end else begin
            r_ram_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_store  <= store;
                        r_size   <= size;
                        r_sext   <= sext;
                        r_offset <= address[2:0];
                        r_wdata  <= wdata;
                        r_err    <= w_reject;
                        if (w_reject) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ram_address <= address[ADDR_BITS+2:3];
                            if (store && (size == 2'b11)) begin
                                r_ram_in    <= wdata;
                                r_ram_write <= 1'b1;
                                r_state     <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (r_store) begin
                        r_ram_in    <= w_merged;
                        r_ram_write <= 1'b1;
                        r_state     <= S_WR;
                    end else begin
                        r_rdata <= w_load_result;
                        r_state <= S_DONE;
                    end
                end
                S_WR:    r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = done & r_err;
    assign rdata       = r_rdata;
    assign ram_address = r_ram_address;
    assign ram_in      = r_ram_in;
    assign ram_write   = r_ram_write;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Bench for dmem_access_ctrl with a negedge RAM and a byte-level
//            reference model of memory and load results.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req;
    logic        store;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] address;
    logic [63:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic [7:0]  ram_address;
    logic [63:0] ram_in;
    logic        ram_write;
    logic [63:0] ram_out;

    logic [63:0] ram_mem [0:255];
    logic [63:0] ref_mem [0:255];
    logic [63:0] model_rdata;

    int n_pass  = 0;
    int n_total = 0;

    dmem_access_ctrl #(.ADDR_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .store       (store),
        .size        (size),
        .sext        (sext),
        .address     (address),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_write   (ram_write),
        .ram_out     (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data RAM: samples address and write on the falling edge, read-first.
    always @(negedge clock) begin
        ram_out <= ram_mem[ram_address];
        if (ram_write) ram_mem[ram_address] <= ram_in;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                               input int n, input bit sx);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (sx && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // One request from idle; all expectations come from the byte-level model.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] got);
        int          n;
        int          idx;
        int          off;
        int          lat_exp;
        int          cyc;
        int          nwr;
        bit          e;
        logic [63:0] w;
        n   = 1 << sz;
        e   = ((a % 64'(n)) != 64'd0) || (a >= 64'd2048);
        idx = e ? 0 : int'(a / 64'd8);
        off = int'(a % 64'd8);
        if (e)                    lat_exp = 1;
        else if (st && n == 8)    lat_exp = 2;
        else if (st)              lat_exp = 3;
        else                      lat_exp = 2;
        if (!e && !st) model_rdata = model_load(ref_mem[idx], off, n, sx);
        if (!e && st) begin
            w = ref_mem[idx];
            for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[idx] = w;
        end
        check("ready_before_req", 64'(ready), 64'd1);
        req = 1'b1; store = st; size = sz; sext = sx; address = a; wdata = wd;
        @(posedge clock);
        #1 req = 1'b0;
        cyc = 0;
        nwr = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (ram_write) nwr++;
        end while (!done && cyc < 8);
        check("latency", 64'(cyc), 64'(lat_exp));
        check("err", 64'(err), 64'(e));
        check("ready_in_done", 64'(ready), 64'd0);
        check("rdata", rdata, model_rdata);
        check("write_cycles", 64'(nwr), (st && !e) ? 64'd1 : 64'd0);
        if (!e) check("ram_address", 64'(ram_address), 64'(idx));
        got = rdata;
        @(posedge clock);
        #1;
        if (!e) check("mem_word", ram_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] bp_addr [4];
        logic [63:0] bp_exp  [4];
        int          acc_cyc [4];
        int          k;
        int          nd;
        int          nwr;
        bit          acc;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] <= {$urandom, $urandom};
        end
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];
        model_rdata = 64'd0;
        req = 1'b0; store = 1'b0; size = 2'b00; sext = 1'b0;
        address = 64'd0; wdata = 64'd0;

        // Reset state
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ram_write", 64'(ram_write), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_ram_in", ram_in, 64'd0);
        check("rst_ram_address", 64'(ram_address), 64'd0);
        @(posedge clock);
        #1;

        ram_mem[5] <= 64'h8000_0000_7FFF_8001;
        ref_mem[5]  = 64'h8000_0000_7FFF_8001;

        // Doubleword round trip
        run_op(1'b1, 2'b11, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, got);
        check("dw_word3", ram_mem[3], 64'h0123_4567_89AB_CDEF);
        run_op(1'b0, 2'b11, 1'b1, 64'h18, 64'd0, got);
        check("dw_load", got, 64'h0123_4567_89AB_CDEF);

        // Byte read-modify-write
        run_op(1'b1, 2'b00, 1'b0, 64'h1D, 64'hFF, got);
        check("byte_rmw_word3", ram_mem[3], 64'h0123_FF67_89AB_CDEF);

        // Load extension
        run_op(1'b0, 2'b10, 1'b1, 64'h2C, 64'd0, got);
        check("ldursw", got, 64'hFFFF_FFFF_8000_0000);
        run_op(1'b0, 2'b01, 1'b0, 64'h28, 64'd0, got);
        check("half_zext", got, 64'h0000_0000_0000_8001);
        run_op(1'b0, 2'b00, 1'b0, 64'h2A, 64'd0, got);
        check("byte_zext", got, 64'h0000_0000_0000_00FF);

        // Rejected requests leave rdata alone
        run_op(1'b0, 2'b01, 1'b0, 64'h03, 64'd0, got);
        check("misaligned_rdata", got, 64'h0000_0000_0000_00FF);
        run_op(1'b0, 2'b11, 1'b0, 64'h800, 64'd0, got);
        check("range_rdata", got, 64'h0000_0000_0000_00FF);

        // Back-pressure: req held high across four loads
        bp_addr[0] = 64'h18; bp_addr[1] = 64'h28; bp_addr[2] = 64'h40; bp_addr[3] = 64'h10;
        for (int i = 0; i < 4; i++) bp_exp[i] = model_load(ref_mem[int'(bp_addr[i] / 64'd8)], 0, 8, 1'b0);
        store = 1'b0; size = 2'b11; sext = 1'b0; address = bp_addr[0]; req = 1'b1;
        k = 0;
        nd = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clock);
            if (done) begin
                if (nd < 4) check("bp_rdata", rdata, bp_exp[nd]);
                nd++;
            end
            acc = ready && req;
            if (acc && k < 4) begin
                acc_cyc[k] = cyc;
                k++;
            end
            @(posedge clock);
            #1;
            if (acc) begin
                if (k < 4) address = bp_addr[k];
                else req = 1'b0;
            end
        end
        req = 1'b0;
        model_rdata = bp_exp[3];
        check("bp_accepts", 64'(k), 64'd4);
        check("bp_dones", 64'(nd), 64'd4);
        for (int i = 1; i < 4; i++)
            if (i < k) check("bp_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);

        // Reset in the RD cycle of a byte store: nothing written, no done
        got = ref_mem[8];
        req = 1'b1; store = 1'b1; size = 2'b00; sext = 1'b0; address = 64'h41; wdata = 64'h5A;
        @(posedge clock);
        #1 req = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_rdata = 64'd0;
        nd = 0;
        nwr = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            if (done) nd++;
            if (ram_write) nwr++;
        end
        check("rst_rd_done", 64'(nd), 64'd0);
        check("rst_rd_writes", 64'(nwr), 64'd0);
        check("rst_rd_ready", 64'(ready), 64'd1);
        check("rst_rd_mem", ram_mem[8], got);
        check("rst_rd_rdata", rdata, 64'd0);
        @(posedge clock);
        #1;

        // Reset in the WR cycle: the registered write still lands whole
        got = ref_mem[9];
        got[23:16] = 8'hC3;
        ref_mem[9] = got;
        req = 1'b1; store = 1'b1; size = 2'b00; sext = 1'b0; address = 64'h4A; wdata = 64'hC3;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        nwr = 0;
        @(negedge clock);
        if (ram_write) nwr++;
        @(posedge clock);
        #1 reset = 1'b0;
        nd = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            if (done) nd++;
            if (ram_write) nwr++;
        end
        check("rst_wr_writes", 64'(nwr), 64'd1);
        check("rst_wr_done", 64'(nd), 64'd0);
        check("rst_wr_mem", ram_mem[9], ref_mem[9]);
        check("rst_wr_ready", 64'(ready), 64'd1);
        @(posedge clock);
        #1;

        // Reset together with req drops the request
        got = ref_mem[2];
        req = 1'b1; store = 1'b1; size = 2'b11; address = 64'h10; wdata = 64'hDEAD_BEEF_0000_1111;
        reset = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        reset = 1'b0;
        nd = 0;
        nwr = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            if (done) nd++;
            if (ram_write) nwr++;
        end
        check("rst_req_done", 64'(nd + nwr), 64'd0);
        check("rst_req_mem", ram_mem[2], got);
        @(posedge clock);
        #1;

        // Randomized requests against the model
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  rsz;
            logic [63:0] ra;
            int          sel;
            int          n;
            rsz = 2'($urandom_range(0, 3));
            n   = 1 << rsz;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = 64'($urandom_range(0, 127));
            else if (sel == 1) ra = 64'd2048 + 64'($urandom_range(0, 4095));
            else               ra = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 8 / n - 1) * n);
            run_op(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra,
                   {$urandom, $urandom}, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
